// File: rtl/rotary_nav.sv
// Rotary encoder front end: synchronise, debounce and quadrature-decode the raw pins, keeping one wrapping index per bank.
// Optional macro ROT_ACCEL_EN: repeated same-direction steps within ACCEL_CYCLES move the index by 4.
`timescale 1ns/1ps
module rotary_nav #(
    parameter int CLK_FREQ     = 50,
    parameter int SETTLE_US    = 40,
    parameter int ADDR_W       = 5,
    parameter int ACCEL_CYCLES = 2500000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rot_a,
    input  logic                  rot_b,
    input  logic                  rot_ctr,
    input  logic [1:0]            bank_sel,
    input  logic                  clear,
    output logic                  step_prev,
    output logic                  step_next,
    output logic                  press,
    output logic [ADDR_W-1:0]     addr,
    output logic [4*ADDR_W-1:0]   addr_all
);
    localparam int SETTLE = CLK_FREQ * SETTLE_US;
    localparam int CW     = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {REST, P1, P2, P3, N1, N2, N3, ERR} state_t;

    // bit 0 = a, bit 1 = b, bit 2 = push switch
    logic [2:0] raw;
    logic [2:0] sync1_q, sync2_q, last_q, filt_q, filt_d;

    assign raw = {rot_ctr, rot_b, rot_a};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            last_q  <= '0;
            filt_q  <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            last_q  <= sync2_q;
            filt_q  <= filt_d;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_filt
        // run_d counts how many cycles the synced value has held, including this one
        logic [CW-1:0] run_q, run_d;

        assign run_d = (sync2_q[i] != last_q[i]) ? CW'(1) :
                       (run_q == CW'(SETTLE))    ? run_q  : run_q + CW'(1);
        assign filt_d[i] = (sync2_q[i] != filt_q[i] && run_d == CW'(SETTLE)) ? sync2_q[i] : filt_q[i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) run_q <= '0;
            else        run_q <= run_d;
        end
    end

    state_t     state_q, state_d;
    logic       prev_d, next_d, press_d;
    logic [1:0] ab;

    assign ab      = {filt_q[0], filt_q[1]};
    assign press_d = filt_d[2] & ~filt_q[2];

    always_comb begin
        state_d = state_q;
        prev_d  = 1'b0;
        next_d  = 1'b0;
        unique case (state_q)
            REST: case (ab)
                2'b10: state_d = P1;
                2'b01: state_d = N1;
                2'b11: state_d = ERR;
                default: ;
            endcase
            P1: case (ab)
                2'b11: state_d = P2;
                2'b00: state_d = REST;
                2'b01: state_d = ERR;
                default: ;
            endcase
            P2: case (ab)
                2'b01: state_d = P3;
                2'b10: state_d = P1;
                2'b00: state_d = ERR;
                default: ;
            endcase
            P3: case (ab)
                2'b00: begin state_d = REST; prev_d = 1'b1; end
                2'b11: state_d = P2;
                2'b10: state_d = ERR;
                default: ;
            endcase
            N1: case (ab)
                2'b11: state_d = N2;
                2'b00: state_d = REST;
                2'b10: state_d = ERR;
                default: ;
            endcase
            N2: case (ab)
                2'b10: state_d = N3;
                2'b01: state_d = N1;
                2'b00: state_d = ERR;
                default: ;
            endcase
            N3: case (ab)
                2'b00: begin state_d = REST; next_d = 1'b1; end
                2'b11: state_d = N2;
                2'b01: state_d = ERR;
                default: ;
            endcase
            default: if (ab == 2'b00) state_d = REST;
        endcase
    end

    logic [ADDR_W-1:0] amt;

`ifdef ROT_ACCEL_EN
    localparam int IW = $clog2(ACCEL_CYCLES + 1);
    logic [IW-1:0] ivl_q;
    logic          dir_q, dir_vld_q;

    // dir_q = 1 for the clockwise (step_next) direction
    assign amt = (dir_vld_q && ivl_q < IW'(ACCEL_CYCLES) && dir_q == next_d) ? ADDR_W'(4) : ADDR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ivl_q     <= '0;
            dir_q     <= 1'b0;
            dir_vld_q <= 1'b0;
        end else if (prev_d || next_d) begin
            ivl_q     <= '0;
            dir_q     <= next_d;
            dir_vld_q <= 1'b1;
        end else if (ivl_q != IW'(ACCEL_CYCLES)) begin
            ivl_q <= ivl_q + IW'(1);
        end
    end
`else
    assign amt = ADDR_W'(1);
`endif

    logic [3:0][ADDR_W-1:0] idx_q, idx_d;
    logic                   step_prev_q, step_next_q, press_q;

    always_comb begin
        idx_d = idx_q;
        if (clear)       idx_d = '0;
        else if (next_d) idx_d[bank_sel] = idx_q[bank_sel] + amt;
        else if (prev_d) idx_d[bank_sel] = idx_q[bank_sel] - amt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= REST;
            idx_q       <= '0;
            step_prev_q <= 1'b0;
            step_next_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            step_prev_q <= prev_d;
            step_next_q <= next_d;
            press_q     <= press_d;
        end
    end

    assign step_prev = step_prev_q;
    assign step_next = step_next_q;
    assign press     = press_q;
    assign addr      = idx_q[bank_sel];
    assign addr_all  = idx_q;
endmodule

// File: tb/tb_rotary_nav.sv
// Bench for rotary_nav: directed scenarios plus random encoder traffic against a window/displacement model.
`timescale 1ns/1ps
module tb_rotary_nav;
    localparam int SETTLE = 4;
    localparam int ADDR_W = 5;
    localparam int ACCEL  = 100;

    logic clk = 0, rst_n = 0, rot_a = 0, rot_b = 0, rot_ctr = 0, clear = 0;
    logic [1:0] bank_sel = 0;
    logic step_prev, step_next, press;
    logic [ADDR_W-1:0]   addr;
    logic [4*ADDR_W-1:0] addr_all;

    int total = 0, bad = 0, nprint = 0;
    int np = 0, nn = 0, npr = 0;

    always #5 clk = ~clk;

    rotary_nav #(.CLK_FREQ(1), .SETTLE_US(4), .ADDR_W(ADDR_W), .ACCEL_CYCLES(ACCEL)) dut (
        .clk(clk), .rst_n(rst_n), .rot_a(rot_a), .rot_b(rot_b), .rot_ctr(rot_ctr),
        .bank_sel(bank_sel), .clear(clear), .step_prev(step_prev), .step_next(step_next),
        .press(press), .addr(addr), .addr_all(addr_all));

    // ---------------- behavioural model ----------------
    bit                h [3][SETTLE+2];
    bit                mf [3];
    logic [ADDR_W-1:0] mi [4];
    bit                mp, mn, mpr, merr, m_has, m_dir;
    int                d, mlast, e, m_last_e;

    function automatic int qpos(bit a, bit b);
        case ({a, b})
            2'b00: return 0;
            2'b10: return 1;
            2'b11: return 2;
            default: return 3;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            foreach (h[c, k]) h[c][k] = 0;
            foreach (mf[c]) mf[c] = 0;
            foreach (mi[b]) mi[b] = '0;
            {mp, mn, mpr, merr, m_has, m_dir} = '0;
            d = 0; mlast = 0; e = 0; m_last_e = 0;
        end else begin
            int p, dl;
            bit same;
            logic [ADDR_W-1:0] amt;
            bit [2:0] rawv;
            e++;
            mp = 0; mn = 0; mpr = 0;
            // displacement along the gray sequence; a full +4/-4 loop back to 00 is one detent
            p = qpos(mf[0], mf[1]);
            if (merr) begin
                if (p == 0) begin merr = 0; d = 0; end
            end else if (p != mlast) begin
                dl = (p - mlast + 4) % 4;
                if (dl == 2) merr = 1;
                else begin
                    d += (dl == 1) ? 1 : -1;
                    if (p == 0) begin
                        mp = (d == 4);
                        mn = (d == -4);
                        d  = 0;
                    end
                end
            end
            mlast = p;
            amt = 1;
`ifdef ROT_ACCEL_EN
            if (mp || mn) begin
                if (m_has && (e - m_last_e - 1) < ACCEL && m_dir == mn) amt = 4;
                m_has = 1; m_dir = mn; m_last_e = e;
            end
`endif
            if (clear) foreach (mi[b]) mi[b] = '0;
            else if (mn) mi[bank_sel] = mi[bank_sel] + amt;
            else if (mp) mi[bank_sel] = mi[bank_sel] - amt;
            // filtered value follows a raw sample seen SETTLE times in a row, two samples back
            rawv = {rot_ctr, rot_b, rot_a};
            for (int c = 0; c < 3; c++) begin
                for (int k = SETTLE + 1; k > 0; k--) h[c][k] = h[c][k-1];
                h[c][0] = rawv[c];
                same = 1;
                for (int k = 3; k <= SETTLE + 1; k++) if (h[c][k] != h[c][2]) same = 0;
                if (same && h[c][2] != mf[c]) begin
                    if (c == 2 && h[c][2]) mpr = 1;
                    mf[c] = h[c][2];
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            total++;
            if ({step_prev, step_next, press} !== {mp, mn, mpr} || addr !== mi[bank_sel] ||
                addr_all !== {mi[3], mi[2], mi[1], mi[0]}) begin
                bad++;
                if (nprint < 10)
                    $display("FAIL cycle %0d: dut prev/next/press=%b%b%b addr=%0d all=%h, model %b%b%b addr=%0d all=%h",
                             e, step_prev, step_next, press, addr, addr_all,
                             mp, mn, mpr, mi[bank_sel], {mi[3], mi[2], mi[1], mi[0]});
                nprint++;
            end
            np += int'(step_prev);
            nn += int'(step_next);
            npr += int'(press);
        end
    end

    // ---------------- stimulus ----------------
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ph(bit a, bit b, int n);
        rot_a = a; rot_b = b;
        cyc(n);
    endtask

    task automatic detent_ccw(int n);
        ph(1, 0, n); ph(1, 1, n); ph(0, 1, n); ph(0, 0, n);
    endtask

    task automatic detent_cw(int n);
        ph(0, 1, n); ph(1, 1, n); ph(1, 0, n); ph(0, 0, n);
    endtask

    logic [1:0] ptab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    initial begin
        int b0, p;
        cyc(3);
        chk("reset addr_all", 32'(addr_all), 0);
        chk("reset pulses", 32'({step_prev, step_next, press}), 0);
        rst_n = 1;
        cyc(2);

`ifdef ROT_ACCEL_EN
        detent_cw(15);
        chk("accel first", 32'(addr), 1);
        detent_cw(15);
        chk("accel fast", 32'(addr), 5);
        cyc(200);
        detent_cw(10); cyc(10);
        chk("accel slow", 32'(addr), 6);
`else
        b0 = np;
        detent_ccw(10); cyc(10);
        chk("ccw prev count", 32'(np - b0), 1);
        chk("ccw next count", 32'(nn), 0);
        chk("ccw addr wrap", 32'(addr), 31);
        chk("ccw addr_all", 32'(addr_all), 31);
        chk("model bank0", 32'(mi[0]), 31);

        bank_sel = 2; b0 = nn;
        repeat (3) detent_cw(10);
        cyc(10);
        chk("cw next count", 32'(nn - b0), 3);
        chk("cw bank2 addr", 32'(addr), 3);
        chk("cw addr_all", 32'(addr_all), (3 << 10) | 31);
        bank_sel = 0; cyc(1);
        chk("bank0 kept", 32'(addr), 31);

        b0 = np + nn;
        foreach (ptab[g]) begin
            rot_a = 1; cyc(g == 1 ? 3 : 2);
            rot_a = 0; cyc(10);
        end
        ph(1, 0, 10); ph(0, 0, 10);
        chk("glitch no step", 32'(np + nn - b0), 0);

        bank_sel = 1;
        repeat (5) detent_cw(10);
        cyc(10);
        chk("bank1 five", 32'(addr), 5);
        ph(0, 1, 10); ph(1, 1, 10); ph(1, 0, 10);
        rot_a = 0; rot_b = 0;
        cyc(SETTLE + 2);
        clear = 1;
        cyc(1);
        chk("clear step_next", 32'(step_next), 1);
        chk("clear wins", 32'(addr_all), 0);
        clear = 0;
        cyc(10);

        bank_sel = 0; b0 = np + nn;
        ph(1, 1, 10); ph(1, 0, 10); ph(0, 0, 10);
        chk("err no step", 32'(np + nn - b0), 0);
        b0 = np;
        detent_ccw(10); cyc(10);
        chk("after err prev", 32'(np - b0), 1);
        chk("after err addr", 32'(addr), 31);
`endif

        b0 = npr;
        rot_ctr = 1; cyc(20);
        rot_ctr = 0; cyc(20);
        chk("press once", 32'(npr - b0), 1);

        p = 0;
        for (int s = 0; s < 350; s++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 7)       p = (p + 1) % 4;
            else if (r < 14) p = (p + 3) % 4;
            else if (r == 14) p = (p + 2) % 4;
            else if (r == 15) rot_ctr = ~rot_ctr;
            else if (r == 16) begin rot_a = ~rot_a; cyc($urandom_range(1, 4)); end
            {rot_a, rot_b} = ptab[p];
            if ($urandom_range(0, 3) == 0) bank_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) begin clear = 1; cyc(1); clear = 0; end
            cyc($urandom_range(1, 12));
        end
        cyc(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
